// File: rtl/bus_decoder_ws_pkg.sv
// Shared definitions for the CPU bus decoder with per-region wait states.
// Holds the system memory-map region indices, the wait-code and error-data
// constants and the decoder state encoding. Everything that decodes or
// times a bus access imports this package.
package bus_decoder_ws_pkg;

  // Region indices of the system memory map.
  localparam int CPU_RAM    = 0;
  localparam int VDP        = 1;
  localparam int STATUS     = 2;
  localparam int DSP        = 3;
  localparam int PAD        = 4;
  localparam int COP_RAM    = 5;
  localparam int BOOTLOADER = 6;
  localparam int FLASH_CTRL = 7;
  localparam int FLASH_READ = 8;

  // A region whose wait code is all ones is timed by the slave's own ready.
  localparam logic [3:0] WAIT_USE_READY = 4'hF;

  // Read data returned when an access is terminated by the timeout.
  localparam logic [31:0] BUS_ERROR_DATA = 32'hDEADBEEF;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } busState_e;

  // True when a latched wait code selects slave-ready timing.
  function automatic logic isReadyMode(input logic [3:0] waitCode);
    return waitCode == WAIT_USE_READY;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state timer for the bus decoder.
// Contains a loadable down-counter with a zero flag, used to time
// fixed-wait regions, and (when BUS_TIMEOUT_EN is defined) an up-counter
// that flags when a ready-mode access has lasted TIMEOUT_CYCLES cycles.
// Without BUS_TIMEOUT_EN the timeout flag is tied low.
module bus_wait_timer
  import bus_decoder_ws_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] loadValue_i,
  input  logic       countEn_i,
  input  logic       timeoutEn_i,
  output logic       zero_o,
  output logic       timeout_o
);

  logic [3:0] waitCnt_q;
  logic [3:0] waitCnt_d;

  // Next value of the wait counter: load on access start, then count down
  // to zero and hold there until the decoder leaves the access.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (load_i) begin
      waitCnt_d = loadValue_i;
    end else if (countEn_i && (waitCnt_q != 4'd0)) begin
      waitCnt_d = waitCnt_q - 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt_q <= 4'd0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

  assign zero_o = (waitCnt_q == 4'd0);

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] toCnt_q;
  logic [TW-1:0] toCnt_d;

  // Timeout counter holds the number of the current access cycle (starting
  // at 1 in the first cycle) and saturates at the limit so it cannot wrap.
  always_comb begin
    toCnt_d = toCnt_q;
    if (load_i) begin
      toCnt_d = TW'(1);
    end else if (timeoutEn_i && (toCnt_q != TO_LIMIT)) begin
      toCnt_d = toCnt_q + TW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      toCnt_q <= '0;
    end else begin
      toCnt_q <= toCnt_d;
    end
  end

  assign timeout_o = timeoutEn_i && (toCnt_q == TO_LIMIT);
`else
  logic unusedTimeoutInputs;

  assign unusedTimeoutInputs = timeoutEn_i ^ (TIMEOUT_CYCLES == 0);
  assign timeout_o           = 1'b0;
`endif

endmodule

// File: rtl/bus_decoder_ws.sv
// CPU bus decoder with a per-region wait-state engine.
// Decodes the CPU address into a one-hot slave enable, holds the enable and
// write strobes for the duration of the access, generates the CPU ready
// pulse from either a fixed wait count or the selected slave's ready, and
// muxes the selected slave's read data back to the CPU.
// Optional macro BUS_TIMEOUT_EN: terminates ready-mode accesses that last
// TIMEOUT_CYCLES cycles, returning BUS_ERROR_DATA and raising a sticky
// bus_error flag with the offending region.
module bus_decoder_ws
  import bus_decoder_ws_pkg::*;
#(
  parameter int ADDR_WIDTH     = 20,
  parameter int SEL_LSB        = 16,
  parameter int SEL_BITS       = 3,
  parameter int TOP_BIT_REGION = 1,
  parameter int NUM_REGIONS    = 2**SEL_BITS + TOP_BIT_REGION,
  parameter logic [4*NUM_REGIONS-1:0] WAIT_STATES = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    cpu_address,
  input  logic                     cpu_mem_valid,
  input  logic [3:0]               cpu_wstrb,
  output logic                     cpu_mem_ready,
  output logic [31:0]              cpu_rdata,
  output logic [NUM_REGIONS-1:0]   slave_en,
  output logic [NUM_REGIONS-1:0]   slave_write_en,
  output logic [3:0]               slave_wstrb,
  input  logic [32*NUM_REGIONS-1:0] slave_rdata,
  input  logic [NUM_REGIONS-1:0]   slave_ready,
  output logic                     bus_error,
  output logic [SEL_BITS:0]        bus_error_region,
  input  logic                     bus_error_clear
);

  localparam int REGION_W = SEL_BITS + 1;
  localparam int NUM_SEL  = 2**SEL_BITS;

  busState_e             state_q;
  logic [REGION_W-1:0]   regionIdx_q;
  logic [3:0]            waitCode_q;
  logic [NUM_REGIONS-1:0] slaveEn_q;
  logic [NUM_REGIONS-1:0] slaveWriteEn_q;
  logic [3:0]            slaveWstrb_q;

  logic [REGION_W-1:0]   regionSel;
  logic [NUM_REGIONS-1:0] selOneHot;
  logic [3:0]            selWaitCode;
  logic                  accepting;
  logic                  accessing;
  logic                  readyMode;
  logic                  slaveHit;
  logic                  waitZero;
  logic                  timeoutHit;
  logic                  doneHit;
  logic                  timeoutTaken;
  logic                  unusedInputs;

  // Region index of the incoming request: the top address bit overrides the
  // select field when the extra top region is enabled.
  always_comb begin
    regionSel = {1'b0, cpu_address[SEL_LSB +: SEL_BITS]};
    if ((TOP_BIT_REGION != 0) && cpu_address[ADDR_WIDTH-1]) begin
      regionSel = REGION_W'(NUM_SEL);
    end
  end

  assign selOneHot   = NUM_REGIONS'(1) << regionSel;
  assign selWaitCode = WAIT_STATES[4*regionSel +: 4];

  // Only the select field and the top bit take part in decoding.
  assign unusedInputs = ^{cpu_address, bus_error_clear};

  assign accepting = (state_q == ST_IDLE) && cpu_mem_valid;
  assign accessing = (state_q == ST_ACCESS);
  assign readyMode = isReadyMode(waitCode_q);
  assign slaveHit  = slave_ready[regionIdx_q];

  bus_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accepting),
    .loadValue_i (selWaitCode),
    .countEn_i   (accessing && !readyMode),
    .timeoutEn_i (accessing && readyMode),
    .zero_o      (waitZero),
    .timeout_o   (timeoutHit)
  );

  // Access completion: fixed regions finish when the wait counter is empty,
  // ready regions when the selected slave answers or the timeout expires.
  always_comb begin
    doneHit      = 1'b0;
    timeoutTaken = 1'b0;
    if (accessing) begin
      if (readyMode) begin
        doneHit      = slaveHit || timeoutHit;
        timeoutTaken = !slaveHit && timeoutHit;
      end else begin
        doneHit = waitZero;
      end
    end
  end

  // A reset arriving during the completing cycle aborts the access, so the
  // ready pulse is suppressed while reset is high.
  assign cpu_mem_ready = doneHit && !reset;

  // Read data is only driven in the ready cycle; writes return zero and a
  // timed-out access returns the error pattern.
  always_comb begin
    cpu_rdata = '0;
    if (cpu_mem_ready) begin
      if (timeoutTaken) begin
        cpu_rdata = BUS_ERROR_DATA;
      end else if (slaveWstrb_q == 4'b0000) begin
        cpu_rdata = slave_rdata[32*regionIdx_q +: 32];
      end
    end
  end

  // Decoder FSM: latch the request in IDLE, hold the registered enables
  // through ACCESS, then spend one guard cycle in DONE with everything low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      regionIdx_q    <= '0;
      waitCode_q     <= 4'd0;
      slaveEn_q      <= '0;
      slaveWriteEn_q <= '0;
      slaveWstrb_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_mem_valid) begin
            regionIdx_q    <= regionSel;
            waitCode_q     <= selWaitCode;
            slaveWstrb_q   <= cpu_wstrb;
            slaveEn_q      <= selOneHot;
            slaveWriteEn_q <= (cpu_wstrb != 4'b0000) ? selOneHot : '0;
            state_q        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (doneHit) begin
            slaveEn_q      <= '0;
            slaveWriteEn_q <= '0;
            slaveWstrb_q   <= 4'd0;
            state_q        <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          slaveEn_q      <= '0;
          slaveWriteEn_q <= '0;
          slaveWstrb_q   <= 4'd0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign slave_en       = slaveEn_q;
  assign slave_write_en = slaveWriteEn_q;
  assign slave_wstrb    = slaveWstrb_q;

`ifdef BUS_TIMEOUT_EN
  logic                busError_q;
  logic [REGION_W-1:0] busErrorRegion_q;

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      busError_q       <= 1'b0;
      busErrorRegion_q <= '0;
    end else if (timeoutTaken) begin
      busError_q       <= 1'b1;
      busErrorRegion_q <= regionIdx_q;
    end else if (bus_error_clear) begin
      busError_q <= 1'b0;
    end
  end

  assign bus_error        = busError_q;
  assign bus_error_region = busErrorRegion_q;
`else
  assign bus_error        = 1'b0;
  assign bus_error_region = '0;
`endif

endmodule

// File: tb/tb_bus_decoder_ws.sv
// Self-checking bench for bus_decoder_ws: a table of fixed-wait accesses
// plus hand-written sequences for ready mode, timeout, reset abort and
// back-to-back requests. Timeout checks follow BUS_TIMEOUT_EN.
module tb_bus_decoder_ws;

  localparam int NR = 9;
  localparam logic [35:0] WS = 36'hFF210F530;

  logic          clk;
  logic          reset;
  logic [19:0]   cpu_address;
  logic          cpu_mem_valid;
  logic [3:0]    cpu_wstrb;
  logic          cpu_mem_ready;
  logic [31:0]   cpu_rdata;
  logic [NR-1:0] slave_en;
  logic [NR-1:0] slave_write_en;
  logic [3:0]    slave_wstrb;
  logic [32*NR-1:0] slave_rdata;
  logic [NR-1:0] slave_ready;
  logic          bus_error;
  logic [3:0]    bus_error_region;
  logic          bus_error_clear;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [19:0] addr;
    logic [3:0]  wstrb;
    int          region;
    int          latency;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[7];

  bus_decoder_ws #(
    .ADDR_WIDTH     (20),
    .SEL_LSB        (16),
    .SEL_BITS       (3),
    .TOP_BIT_REGION (1),
    .WAIT_STATES    (WS),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_address      (cpu_address),
    .cpu_mem_valid    (cpu_mem_valid),
    .cpu_wstrb        (cpu_wstrb),
    .cpu_mem_ready    (cpu_mem_ready),
    .cpu_rdata        (cpu_rdata),
    .slave_en         (slave_en),
    .slave_write_en   (slave_write_en),
    .slave_wstrb      (slave_wstrb),
    .slave_rdata      (slave_rdata),
    .slave_ready      (slave_ready),
    .bus_error        (bus_error),
    .bus_error_region (bus_error_region),
    .bus_error_clear  (bus_error_clear)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] expData(input int i);
    return 32'h5A00_0000 | (32'(i) << 16) | 32'(i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // One fixed-wait access from IDLE through DONE, checked cycle by cycle.
  task automatic applyStimulus(input int idx, input vec_t v);
    int          n;
    logic        seenReady;
    logic [31:0] rd;
    logic        enOk;
    logic        weOk;
    logic        wsOk;
    logic [NR-1:0] expEn;
    logic [NR-1:0] expWe;
    expEn = NR'(1) << v.region;
    expWe = (v.wstrb != 4'b0000) ? expEn : '0;
    @(negedge clk);
    cpu_address   = v.addr;
    cpu_wstrb     = v.wstrb;
    cpu_mem_valid = 1'b1;
    n = 0; seenReady = 1'b0; rd = '0; enOk = 1'b1; weOk = 1'b1; wsOk = 1'b1;
    while (!seenReady && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (slave_en !== expEn) enOk = 1'b0;
      if (slave_write_en !== expWe) weOk = 1'b0;
      if (slave_wstrb !== v.wstrb) wsOk = 1'b0;
      if (cpu_mem_ready === 1'b1) begin
        seenReady = 1'b1;
        rd = cpu_rdata;
      end
    end
    cpu_mem_valid = 1'b0;
    cpu_address   = '0;
    cpu_wstrb     = 4'b0000;
    checkOutput($sformatf("v%0d latency", idx), 64'(n), 64'(v.latency));
    checkOutput($sformatf("v%0d slave_en held", idx), 64'(enOk), 64'(1));
    checkOutput($sformatf("v%0d write_en held", idx), 64'(weOk), 64'(1));
    checkOutput($sformatf("v%0d wstrb held", idx), 64'(wsOk), 64'(1));
    checkOutput($sformatf("v%0d rdata", idx), 64'(rd), 64'(v.rdata));
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("v%0d done outputs", idx),
                64'({cpu_mem_ready, slave_en, slave_write_en, slave_wstrb, cpu_rdata}), 64'(0));
    @(posedge clk);
  endtask

  initial begin
    logic [11:0] readyPat;
    logic [11:0] enPat;
    logic        flag;
    int          n;

    reset = 1'b1; cpu_address = '0; cpu_mem_valid = 1'b0; cpu_wstrb = 4'b0000;
    slave_ready = '0; bus_error_clear = 1'b0;
    for (int i = 0; i < NR; i++) slave_rdata[32*i +: 32] = expData(i);

    vecs[0] = '{20'h00010, 4'b0000, 0, 1, expData(0)};
    vecs[1] = '{20'h10004, 4'b0011, 1, 4, 32'h0};
    vecs[2] = '{20'h2FFFC, 4'b0000, 2, 6, expData(2)};
    vecs[3] = '{20'h40000, 4'b1111, 4, 1, 32'h0};
    vecs[4] = '{20'h50020, 4'b0000, 5, 2, expData(5)};
    vecs[5] = '{20'h6ABCD, 4'b0000, 6, 3, expData(6)};
    vecs[6] = '{20'h1FFFF, 4'b0000, 1, 4, expData(1)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset outputs",
                64'({cpu_mem_ready, cpu_rdata, slave_en, slave_write_en, slave_wstrb}), 64'(0));
    checkOutput("reset bus_error", 64'({bus_error, bus_error_region}), 64'(0));
    reset = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

    // Ready mode on the top-bit region; ready of region 3 must be ignored.
    @(negedge clk);
    cpu_address = 20'h80000; cpu_mem_valid = 1'b1; slave_ready = 9'b000001000;
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_mem_ready !== 1'b0 || slave_en !== 9'h100) flag = 1'b1;
    end
    checkOutput("ready-mode wait", 64'(flag), 64'(0));
    @(posedge clk);
    @(negedge clk);
    slave_ready[8] = 1'b1;
    #1;
    checkOutput("ready-mode ready", 64'(cpu_mem_ready), 64'(1));
    checkOutput("ready-mode rdata", 64'(cpu_rdata), 64'(expData(8)));
    cpu_mem_valid = 1'b0;
    @(posedge clk);
    #1 slave_ready = '0;
    @(negedge clk);
    checkOutput("ready-mode done", 64'({cpu_mem_ready, slave_en}), 64'(0));
    @(posedge clk);

    // Top bit selects region 8 whatever the select field holds.
    @(negedge clk);
    cpu_address = 20'hF1234; cpu_mem_valid = 1'b1; slave_ready = 9'h100;
    @(posedge clk);
    @(negedge clk);
    checkOutput("top-bit enable", 64'(slave_en), 64'(9'h100));
    checkOutput("top-bit ready", 64'({cpu_mem_ready, cpu_rdata}), 64'({1'b1, expData(8)}));
    cpu_mem_valid = 1'b0;
    @(posedge clk);
    #1 slave_ready = '0;
    @(posedge clk);

    // Region 7 in ready mode with its slave silent.
    @(negedge clk);
    cpu_address = 20'h70000; cpu_mem_valid = 1'b1; slave_ready = 9'h17F;
`ifdef BUS_TIMEOUT_EN
    n = 0; flag = 1'b0;
    while (n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (cpu_mem_ready === 1'b1) break;
      if (bus_error !== 1'b0) flag = 1'b1;
    end
    checkOutput("timeout latency", 64'(n), 64'(8));
    checkOutput("timeout rdata", 64'(cpu_rdata), 64'(32'hDEADBEEF));
    checkOutput("no early bus_error", 64'(flag), 64'(0));
    cpu_mem_valid = 1'b0; slave_ready = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bus_error set", 64'({bus_error, bus_error_region}), 64'({1'b1, 4'd7}));
    bus_error_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_error_clear = 1'b0;
    checkOutput("bus_error cleared", 64'(bus_error), 64'(0));
    @(posedge clk);
`else
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_mem_ready !== 1'b0 || slave_en !== 9'h080) flag = 1'b1;
    end
    checkOutput("no-timeout wait", 64'(flag), 64'(0));
    slave_ready[7] = 1'b1;
    #1;
    checkOutput("late ready", 64'({cpu_mem_ready, cpu_rdata}), 64'({1'b1, expData(7)}));
    checkOutput("bus_error tied", 64'({bus_error, bus_error_region}), 64'(0));
    cpu_mem_valid = 1'b0;
    @(posedge clk);
    #1 slave_ready = '0;
    @(posedge clk);
`endif

    // Reset in the second cycle of a W=5 write to region 2.
    @(negedge clk);
    cpu_address = 20'h20000; cpu_wstrb = 4'b1111; cpu_mem_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre-reset write_en", 64'(slave_write_en), 64'(9'h004));
    reset = 1'b1; cpu_mem_valid = 1'b0; cpu_wstrb = 4'b0000;
    #1;
    checkOutput("reset cycle ready", 64'(cpu_mem_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-reset outputs",
                64'({cpu_mem_ready, cpu_rdata, slave_en, slave_write_en, slave_wstrb}), 64'(0));
    reset = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_mem_ready !== 1'b0 || slave_en !== '0) flag = 1'b1;
    end
    checkOutput("aborted access stays idle", 64'(flag), 64'(0));
    @(posedge clk);
    applyStimulus(7, vecs[0]);

    // Valid held high across back-to-back accesses to region 5 (W=1).
    @(negedge clk);
    cpu_address = 20'h50000; cpu_mem_valid = 1'b1;
    readyPat = '0; enPat = '0; flag = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      readyPat[k] = cpu_mem_ready;
      enPat[k]    = slave_en[5];
      if (cpu_mem_ready === 1'b1 && cpu_rdata !== expData(5)) flag = 1'b1;
      if (k == 11) cpu_mem_valid = 1'b0;
    end
    checkOutput("b2b ready pattern", 64'(readyPat), 64'(12'h222));
    checkOutput("b2b enable pattern", 64'(enPat), 64'(12'h333));
    checkOutput("b2b rdata", 64'(flag), 64'(0));
    @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
